// File: rtl/ready_to_credit_gen.sv
// Ready/valid to credit-flow bridge: registers incoming beats into a show-ahead FIFO
// and returns buffer space to the sender as credit grants.
//
// state | meaning
// WAIT  | post-reset settling; counting INIT_DELAY cycles, no grants, returns/pops flagged
// RUN   | granting min(pending, CMAX) per cycle and reclaiming credits on pop/return
module ready_to_credit_gen #(
  parameter int DATA_W     = 128,
  parameter int EMPTY_W    = 4,
  parameter int CHANNEL_W  = 10,
  parameter int DEPTH_LOG2 = 5,
  parameter int CREDIT_W   = 4,
  parameter int INIT_DELAY = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic                  update_credit,
  output logic [CREDIT_W-1:0]   credit,
  input  logic                  return_credit,
  input  logic [CHANNEL_W-1:0]  avsi_channel,
  input  logic [DATA_W-1:0]     avsi_data,
  input  logic                  avsi_valid,
  input  logic                  avsi_sop,
  input  logic                  avsi_eop,
  input  logic [EMPTY_W-1:0]    avsi_empty,
  output logic [CHANNEL_W-1:0]  avso_channel,
  output logic [DATA_W-1:0]     avso_data,
  output logic                  avso_valid,
  output logic                  avso_sop,
  output logic                  avso_eop,
  output logic [EMPTY_W-1:0]    avso_empty,
  input  logic                  avso_ready,
  output logic                  overflow_err,
  output logic                  credit_err,
  output logic [DEPTH_LOG2:0]   fill_level
);

  localparam int DEPTH  = 2**DEPTH_LOG2;
  localparam int CMAX   = 2**CREDIT_W - 1;
  localparam int PW     = DEPTH_LOG2 + 1;
  localparam int BEAT_W = CHANNEL_W + DATA_W + 2 + EMPTY_W;
  localparam int DLY_W  = $clog2(INIT_DELAY + 2);

  localparam logic [0:0] ST_WAIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic              r_in_valid;
  logic [BEAT_W-1:0] r_in_beat;

  logic [BEAT_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic              r_overflow;

  logic [0:0]        r_state;
  logic [DLY_W-1:0]  r_delay;
  logic [PW-1:0]     r_pending;
  logic              r_update;
  logic [CREDIT_W-1:0] r_credit;
  logic              r_credit_err;

  logic [PW-1:0]     w_fill;
  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic [BEAT_W-1:0] w_head;
  logic [PW-1:0]     w_grant;
  logic [PW:0]       w_pend_sum;
  logic              w_delay_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_in_valid <= 1'b0;
      r_in_beat  <= '0;
    end else begin
      r_in_valid <= avsi_valid;
      r_in_beat  <= {avsi_channel, avsi_data, avsi_sop, avsi_eop,
                     (avsi_valid && avsi_eop) ? avsi_empty : {EMPTY_W{1'b0}}};
    end
  end

  assign w_fill  = r_wr_ptr - r_rd_ptr;
  assign w_empty = (w_fill == '0);
  assign w_full  = (w_fill == PW'(DEPTH));
  assign w_pop   = !w_empty && avso_ready;
  // A full FIFO still accepts a beat when the head leaves in the same cycle.
  assign w_push  = r_in_valid && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= r_in_beat;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (r_in_valid && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  assign w_head = r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];
  assign {avso_channel, avso_data, avso_sop, avso_eop, avso_empty} = w_head;
  assign avso_valid   = !w_empty;
  assign fill_level   = w_fill;
  assign overflow_err = r_overflow;

  assign w_delay_done = ({{(32-DLY_W){1'b0}}, r_delay} + 32'd1 >= 32'(INIT_DELAY));

  always_comb begin
    w_grant = '0;
    if (r_state == ST_RUN) begin
      w_grant = ({{(32-PW){1'b0}}, r_pending} > 32'(CMAX)) ? PW'(CMAX) : r_pending;
    end
    w_pend_sum = {1'b0, r_pending} + (PW+1)'(w_pop) + (PW+1)'(return_credit)
                 - {1'b0, w_grant};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_WAIT;
      r_delay      <= '0;
      r_pending    <= '0;
      r_update     <= 1'b0;
      r_credit     <= '0;
      r_credit_err <= 1'b0;
    end else begin
      case (r_state)
        ST_WAIT: begin
          r_update <= 1'b0;
          r_credit <= '0;
          if (w_pop || return_credit) r_credit_err <= 1'b1;
          if (w_delay_done) begin
            r_state   <= ST_RUN;
            r_pending <= PW'(DEPTH);
          end else begin
            r_delay <= r_delay + DLY_W'(1);
          end
        end
        default: begin
          r_update <= (w_grant != '0);
          r_credit <= CREDIT_W'(w_grant);
          if (w_pend_sum > (PW+1)'(DEPTH)) begin
            r_credit_err <= 1'b1;
            r_pending    <= PW'(DEPTH);
          end else begin
            r_pending <= w_pend_sum[PW-1:0];
          end
        end
      endcase
    end
  end

  assign update_credit = r_update;
  assign credit        = r_credit;
  assign credit_err    = r_credit_err;

endmodule
